// File: rtl/pwm_ramp_ctrl_if.sv
// Bundles the ramp controller's command, configuration and status signals.
// master drives start/stop/config; slave is the controller itself.
interface pwm_ramp_ctrl_if #(
    parameter int PER_W = 16
);
    logic              start;
    logic              stop;
    logic [26:0]       cfg_top;
    logic [26:0]       cfg_cmp_start;
    logic [26:0]       cfg_cmp_end;
    logic [26:0]       cfg_step;
    logic [PER_W-1:0]  cfg_periods;
    logic [31:0]       top_out;
    logic [31:0]       cmp_out;
    logic              busy;
    logic              holding;
    logic              done;

    modport master (
        output start, stop, cfg_top, cfg_cmp_start, cfg_cmp_end, cfg_step, cfg_periods,
        input  top_out, cmp_out, busy, holding, done
    );

    modport slave (
        input  start, stop, cfg_top, cfg_cmp_start, cfg_cmp_end, cfg_step, cfg_periods,
        output top_out, cmp_out, busy, holding, done
    );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// PWM compare ramp controller. Drives an external PWM counter's top and
// compare inputs, stepping the compare value from a start value toward an
// end value once every N PWM periods, then holding at the end value.
// An internal phase counter tracks the external counter so compare updates
// land only at period boundaries.
module pwm_ramp_ctrl #(
    parameter int PER_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    pwm_ramp_ctrl_if.slave     bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RAMP = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [PER_W-1:0] PER_ONE  = {{(PER_W-1){1'b0}}, 1'b1};
    localparam logic [26:0]      STEP_ONE = 27'd1;

    logic [1:0]       state_q,   state_d;
    logic             en_q,      en_d;
    logic [26:0]      top_q,     top_d;
    logic [26:0]      cmp_q,     cmp_d;
    logic [26:0]      end_q,     end_d;
    logic [26:0]      step_q,    step_d;
    logic [PER_W-1:0] periods_q, periods_d;
    logic             dir_up_q,  dir_up_d;
    logic [26:0]      phase_q,   phase_d;
    logic [PER_W-1:0] per_cnt_q, per_cnt_d;
    logic             busy_q,    busy_d;
    logic             holding_q, holding_d;
    logic             done_q,    done_d;

    logic             period_end;
    logic [27:0]      up_sum;
    logic [27:0]      down_limit;
    logic [26:0]      cmp_stepped;

    // One clamped step toward the end value, done in 28 bits so neither
    // direction can wrap past 0 or the 27-bit maximum.
    always_comb begin
        up_sum      = {1'b0, cmp_q} + {1'b0, step_q};
        down_limit  = {1'b0, end_q} + {1'b0, step_q};
        cmp_stepped = end_q;
        if (dir_up_q) begin
            if (up_sum < {1'b0, end_q}) begin
                cmp_stepped = up_sum[26:0];
            end
        end else begin
            if ({1'b0, cmp_q} > down_limit) begin
                cmp_stepped = cmp_q - step_q;
            end
        end
    end

    // Next-state logic: stop beats start, start is only honoured outside RAMP.
    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        top_d      = top_q;
        cmp_d      = cmp_q;
        end_d      = end_q;
        step_d     = step_q;
        periods_d  = periods_q;
        dir_up_d   = dir_up_q;
        phase_d    = phase_q;
        per_cnt_d  = per_cnt_q;
        busy_d     = busy_q;
        holding_d  = holding_q;
        done_d     = 1'b0;

        period_end = (phase_q == top_q);

        // Phase free-runs whenever the counter is enabled, wrapping at top.
        if (state_q != ST_IDLE) begin
            phase_d = period_end ? 27'd0 : phase_q + STEP_ONE;
        end

        if (bus.stop) begin
            state_d   = ST_IDLE;
            en_d      = 1'b0;
            top_d     = '0;
            cmp_d     = '0;
            end_d     = '0;
            step_d    = '0;
            periods_d = '0;
            dir_up_d  = 1'b0;
            phase_d   = '0;
            per_cnt_d = '0;
            busy_d    = 1'b0;
            holding_d = 1'b0;
        end else if (bus.start && (state_q != ST_RAMP)) begin
            state_d   = ST_RAMP;
            en_d      = 1'b1;
            top_d     = bus.cfg_top;
            cmp_d     = bus.cfg_cmp_start;
            end_d     = bus.cfg_cmp_end;
            step_d    = (bus.cfg_step == '0) ? STEP_ONE : bus.cfg_step;
            periods_d = (bus.cfg_periods == '0) ? PER_ONE : bus.cfg_periods;
            dir_up_d  = (bus.cfg_cmp_end >= bus.cfg_cmp_start);
            phase_d   = '0;
            per_cnt_d = '0;
            busy_d    = 1'b1;
            holding_d = 1'b0;
        end else if ((state_q == ST_RAMP) && period_end) begin
            if (per_cnt_q == (periods_q - PER_ONE)) begin
                per_cnt_d = '0;
                if (cmp_q == end_q) begin
                    state_d   = ST_HOLD;
                    busy_d    = 1'b0;
                    holding_d = 1'b1;
                    done_d    = 1'b1;
                end else begin
                    cmp_d = cmp_stepped;
                end
            end else begin
                per_cnt_d = per_cnt_q + PER_ONE;
            end
        end
    end

    // State and output registers; reset returns everything to IDLE at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            en_q      <= 1'b0;
            top_q     <= '0;
            cmp_q     <= '0;
            end_q     <= '0;
            step_q    <= '0;
            periods_q <= '0;
            dir_up_q  <= 1'b0;
            phase_q   <= '0;
            per_cnt_q <= '0;
            busy_q    <= 1'b0;
            holding_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            top_q     <= top_d;
            cmp_q     <= cmp_d;
            end_q     <= end_d;
            step_q    <= step_d;
            periods_q <= periods_d;
            dir_up_q  <= dir_up_d;
            phase_q   <= phase_d;
            per_cnt_q <= per_cnt_d;
            busy_q    <= busy_d;
            holding_q <= holding_d;
            done_q    <= done_d;
        end
    end

    assign bus.top_out = {en_q, 4'b0000, top_q};
    assign bus.cmp_out = {5'b00000, cmp_q};
    assign bus.busy    = busy_q;
    assign bus.holding = holding_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed ramps plus randomized ramps with
// config noise, ignored start pulses, aborts and a mid-ramp reset, all
// checked cycle by cycle against a list-of-compare-values reference model.
module tb_pwm_ramp_ctrl;
    localparam int PER_W = 16;
    localparam int MAXV  = (1 << 27) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pwm_ramp_ctrl_if #(.PER_W(PER_W)) bus ();

    pwm_ramp_ctrl #(.PER_W(PER_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_top"},     64'(bus.top_out), 64'd0);
        check_eq({tag, "_cmp"},     64'(bus.cmp_out), 64'd0);
        check_eq({tag, "_busy"},    64'(bus.busy),    64'd0);
        check_eq({tag, "_holding"}, 64'(bus.holding), 64'd0);
        check_eq({tag, "_done"},    64'(bus.done),    64'd0);
    endtask

    task automatic randomize_cfg();
        bus.cfg_top       = 27'($urandom_range(0, 7));
        bus.cfg_cmp_start = 27'($urandom_range(0, 30));
        bus.cfg_cmp_end   = 27'($urandom_range(0, 30));
        bus.cfg_step      = 27'($urandom_range(0, 9));
        bus.cfg_periods   = PER_W'($urandom_range(0, 3));
    endtask

    // Runs one ramp from the current state. abort_k: 0 none, -1 random cycle,
    // >0 that cycle. noise scrambles cfg inputs and pulses start during RAMP.
    task automatic run_ramp(input int top, input int cs, input int ce, input int st,
                            input int per, input int abort_k, input bit abort_start,
                            input int hold_extra, input bit noise, output int done_k);
        longint vals[$];
        longint v;
        longint st_eff;
        int     per_eff;
        int     dur;
        int     total;
        int     last_k;
        int     ak;
        longint exp_cmp;
        bit     exp_busy;
        bit     exp_hold;
        bit     exp_done;

        // Reference: the list of compare values visited, each held for dur cycles.
        st_eff  = (st == 0) ? 1 : st;
        per_eff = (per == 0) ? 1 : per;
        v = cs;
        vals.push_back(v);
        while (v != ce) begin
            if (ce >= cs) v = (v + st_eff >= ce) ? ce : v + st_eff;
            else          v = (v - st_eff <= ce) ? ce : v - st_eff;
            vals.push_back(v);
        end
        dur    = (top + 1) * per_eff;
        total  = vals.size() * dur;
        last_k = total + 1 + hold_extra;
        ak     = (abort_k < 0) ? int'($urandom_range(1, last_k)) : abort_k;
        done_k = -1;

        bus.cfg_top       = 27'(top);
        bus.cfg_cmp_start = 27'(cs);
        bus.cfg_cmp_end   = 27'(ce);
        bus.cfg_step      = 27'(st);
        bus.cfg_periods   = PER_W'(per);
        bus.start         = 1'b1;
        tick();
        bus.start = 1'b0;

        for (int k = 1; k <= last_k; k++) begin
            if (k <= total) begin
                exp_cmp  = vals[(k - 1) / dur];
                exp_busy = 1'b1;
                exp_hold = 1'b0;
                exp_done = 1'b0;
            end else begin
                exp_cmp  = ce;
                exp_busy = 1'b0;
                exp_hold = 1'b1;
                exp_done = (k == total + 1);
            end
            check_eq("top_out", 64'(bus.top_out), 64'((64'd1 << 31) | 64'(top)));
            check_eq("cmp_out", 64'(bus.cmp_out), 64'(exp_cmp));
            check_eq("busy",    64'(bus.busy),    64'(exp_busy));
            check_eq("holding", 64'(bus.holding), 64'(exp_hold));
            check_eq("done",    64'(bus.done),    64'(exp_done));
            if (bus.done === 1'b1 && done_k < 0) done_k = k;

            if (k == ak) begin
                bus.stop  = 1'b1;
                bus.start = abort_start;
                tick();
                bus.stop  = 1'b0;
                bus.start = 1'b0;
                check_idle("abort");
                for (int i = 0; i < 3; i++) begin
                    tick();
                    check_idle("after_abort");
                end
                $display("[TB] ramp top=%0d %0d->%0d step=%0d per=%0d aborted at cycle %0d",
                         top, cs, ce, st, per, k);
                return;
            end

            if (noise) begin
                randomize_cfg();
                bus.start = (k <= total) && ($urandom_range(0, 7) == 0);
            end
            tick();
            bus.start = 1'b0;
        end
        $display("[TB] ramp top=%0d %0d->%0d step=%0d per=%0d values=%0d done at cycle %0d",
                 top, cs, ce, st, per, vals.size(), done_k);
    endtask

    initial begin
        int dk;

        rst               = 1'b1;
        bus.start         = 1'b0;
        bus.stop          = 1'b0;
        bus.cfg_top       = '0;
        bus.cfg_cmp_start = '0;
        bus.cfg_cmp_end   = '0;
        bus.cfg_step      = '0;
        bus.cfg_periods   = '0;
        #1;
        check_idle("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_idle("post_reset");

        // Up ramp 0->4 step 2: enable at 1, cmp changes at 5 and 9, done at 13.
        run_ramp(3, 0, 4, 2, 1, 0, 1'b0, 3, 1'b0, dk);
        check_eq("up_done_cycle", 64'(dk), 64'd13);

        // Down ramp 10->6->3 (clamped), 4 cycles each.
        run_ramp(1, 10, 3, 4, 2, 0, 1'b0, 2, 1'b0, dk);
        check_eq("down_done_cycle", 64'(dk), 64'd13);

        // Degenerate zeros: top 0, step 0, periods 0 -> one value per cycle.
        run_ramp(0, 0, 2, 0, 0, 0, 1'b0, 2, 1'b0, dk);
        check_eq("zero_cfg_done_cycle", 64'(dk), 64'd4);

        // Stop together with start during RAMP while cmp=2.
        run_ramp(1, 0, 10, 2, 1, 3, 1'b1, 0, 1'b0, dk);
        check_eq("abort_no_done", 64'(dk), 64'hFFFF_FFFF_FFFF_FFFF);

        // Boundaries: clamp at the 27-bit max, clamp at 0, huge step, start==end.
        run_ramp(2, MAXV - 4, MAXV, 3, 1, 0, 1'b0, 1, 1'b0, dk);
        run_ramp(1, 5, 0, 7, 1, 0, 1'b0, 1, 1'b0, dk);
        run_ramp(0, 0, 100, MAXV, 1, 0, 1'b0, 1, 1'b0, dk);
        run_ramp(2, 7, 7, 5, 1, 0, 1'b0, 1, 1'b0, dk);
        check_eq("single_value_done_cycle", 64'(dk), 64'd4);

        // Noisy ramp, then restart straight from HOLD with new config.
        run_ramp(2, 3, 20, 3, 2, 0, 1'b0, 2, 1'b1, dk);
        run_ramp(1, 25, 12, 5, 1, 0, 1'b0, 2, 1'b1, dk);

        // Reset pulse mid-ramp: outputs clear immediately, no activity after.
        bus.cfg_top       = 27'd3;
        bus.cfg_cmp_start = 27'd0;
        bus.cfg_cmp_end   = 27'd20;
        bus.cfg_step      = 27'd1;
        bus.cfg_periods   = PER_W'(2);
        bus.start         = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_eq("pre_rst_busy", 64'(bus.busy), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle("after_rst");
        end
        $display("[TB] mid-ramp reset checked");

        // Randomized ramps with noise and occasional aborts.
        for (int n = 0; n < 30; n++) begin
            int top, cs, ce, st, per, ab;
            top = $urandom_range(0, 7);
            cs  = $urandom_range(0, 30);
            ce  = $urandom_range(0, 30);
            st  = $urandom_range(0, 9);
            per = $urandom_range(0, 3);
            ab  = ($urandom_range(0, 3) == 0) ? -1 : 0;
            run_ramp(top, cs, ce, st, per, ab, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), 1'b1, dk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
